// File: rtl/arb_pkg.sv
// Shared constants and state type for the 16-source round-robin bus arbiter.
package arb_pkg;
  localparam int N_REQ  = 16;
  localparam int SEL_W  = 4;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/MUX_4_to_16_16width.sv
// 16:1 word multiplexer: selects one 16-bit word out of a packed 256-bit bus.
module MUX_4_to_16_16width (
  input  logic [3:0]   s,
  input  logic [255:0] data_bus_in,
  output logic [15:0]  data_out
);
  assign data_out = data_bus_in[s*16 +: 16];
endmodule

// File: rtl/rr_pick_16.sv
// Combinational round-robin picker: first set request bit at or after i_ptr, wrapping mod 16.
module rr_pick_16
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  // Rotate so that bit 0 of w_rot is the requester at i_ptr; 4-bit index add wraps naturally.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign w_rot[gi] = i_req[i_ptr + SEL_W'(gi)];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign o_winner = i_ptr + w_off;
  assign o_any    = |i_req;
endmodule

// File: rtl/rr_bus_arbiter_16.sv
// Round-robin arbiter/sequencer for the shared 16x16-bit word bus.
// Define ARB_BURST_LIMIT_EN to end each tenure after MAX_BURST transfers.
module rr_bus_arbiter_16
  import arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_W-1:0]   data_bus_in,
  input  logic                      bus_ready,
  output logic [N_REQ-1:0]          grant,
  output logic [SEL_W-1:0]          sel,
  output logic [WORD_W-1:0]         data_out,
  output logic                      bus_valid,
  output logic                      busy
);
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  arb_state_t       r_state, w_state_next;
  logic [SEL_W-1:0] r_owner, w_owner_next;
  logic [SEL_W-1:0] r_ptr,   w_ptr_next;
  logic [CNT_W-1:0] r_cnt,   w_cnt_next;
  logic [N_REQ-1:0] r_grant, w_grant_next;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_xfer;
  logic             w_limit_hit;
  logic             w_exit;

  rr_pick_16 u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  MUX_4_to_16_16width u_mux (
    .s           (sel),
    .data_bus_in (data_bus_in),
    .data_out    (data_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_grant <= w_grant_next;
    end
  end

  assign w_xfer      = bus_valid && bus_ready;
  assign w_limit_hit = LIMIT_EN && w_xfer && (r_cnt == CNT_W'(MAX_BURST - 1));
  // Dropping req wins over bus_ready: bus_valid is low, so no transfer can be counted.
  assign w_exit      = !req[r_owner] || w_limit_hit;

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_grant_next = r_grant;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = GRANT;
          w_owner_next = w_winner;
          w_grant_next = N_REQ'(1) << w_winner;
          w_cnt_next   = '0;
        end
      end
      GRANT: begin
        if (w_exit) begin
          w_state_next = IDLE;
          w_grant_next = '0;
          w_ptr_next   = r_owner + SEL_W'(1);
          w_cnt_next   = '0;
        end else if (w_xfer && (r_cnt != '1)) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == GRANT);
    bus_valid = (r_state == GRANT) && req[r_owner];
  end

  assign grant = r_grant;
  assign sel   = r_owner;
endmodule

// File: tb/tb_rr_bus_arbiter_16.sv
// Scoreboard bench for rr_bus_arbiter_16: directed scenarios plus random traffic vs. a reference model.
module tb_rr_bus_arbiter_16;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  req = '0;
  logic [255:0] data_bus = '0;
  logic         bus_ready = 1'b0;
  logic [15:0]  grant;
  logic [3:0]   sel;
  logic [15:0]  data_out;
  logic         bus_valid;
  logic         busy;

  rr_bus_arbiter_16 #(.MAX_BURST(MAXB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_bus_in (data_bus),
    .bus_ready   (bus_ready),
    .grant       (grant),
    .sel         (sel),
    .data_out    (data_out),
    .bus_valid   (bus_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  sel;
    bit          busy;
    bit          valid;
    logic [15:0] word;
  } exp_t;
  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
  } xfer_t;

  exp_t  exp_q[$];
  xfer_t xfer_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    force_a5 = 1'b0;

  // Reference model: owner index (-1 = idle), rotation start, transfers this tenure, last owner.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_sel   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_exit();
    m_ptr   = (m_owner + 1) % 16;
    m_owner = -1;
    m_cnt   = 0;
  endtask

  task automatic step(input bit r, input logic [15:0] q, input bit rdy);
    exp_t  e;
    xfer_t x;
    bit    found;
    @(negedge clk);
    rst = r;
    req = q;
    bus_ready = rdy;
    for (int k = 0; k < 16; k++) data_bus[k*16 +: 16] = 16'($urandom);
    if (force_a5) data_bus[5*16 +: 16] = 16'hA5A5;
    #1;
    e.grant = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    e.sel   = 4'(m_sel);
    e.busy  = (m_owner >= 0);
    e.valid = (m_owner >= 0) && q[m_owner];
    e.word  = data_bus[m_sel*16 +: 16];
    exp_q.push_back(e);
    if (!r && e.valid && rdy) begin
      x.sel  = 4'(m_owner);
      x.data = data_bus[m_owner*16 +: 16];
      xfer_q.push_back(x);
    end
    if (r) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!found && q[(m_ptr + k) % 16]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % 16;
          m_sel   = m_owner;
          m_cnt   = 0;
        end
      end
    end else if (!q[m_owner]) begin
      model_exit();
    end else if (rdy) begin
      m_cnt++;
      if (LIM && m_cnt == MAXB) model_exit();
    end
  endtask

  // Monitor: compares the per-cycle view and every handshake the DUT actually performs.
  initial begin
    exp_t  e;
    xfer_t x;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("bus_valid", 32'(bus_valid), 32'(e.valid));
        chk("data_out", 32'(data_out), 32'(e.word));
      end
      if (!rst && bus_valid && bus_ready) begin
        if (xfer_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got sel=%0d expected no transfer at %0t", sel, $time);
        end else begin
          x = xfer_q.pop_front();
          chk("xfer_sel", 32'(sel), 32'(x.sel));
          chk("xfer_data", 32'(data_out), 32'(x.data));
        end
      end
    end
  end

  initial begin
    logic [15:0] q;
    // Reset then idle
    step(1, 16'h0000, 0);
    step(1, 16'h0000, 0);
    repeat (5) step(0, 16'h0000, 0);
    $display("reset/idle phase done at %0t", $time);

    // Single requester routing word 5
    force_a5 = 1'b1;
    repeat (3) step(0, 16'h0020, 1);
    force_a5 = 1'b0;
    step(0, 16'h0000, 1);
    step(0, 16'h0000, 0);
    $display("single requester phase done at %0t", $time);

    // Round robin between 0 and 15; owner drops after one transfer
    step(1, 16'h0000, 0);
    for (int i = 0; i < 14; i++) begin
      q = 16'h8001;
      if (m_owner >= 0 && m_cnt >= 1) q[m_owner] = 1'b0;
      step(0, q, 1);
    end
    step(0, 16'h0000, 0);
    $display("round-robin phase done at %0t", $time);

    // Held requests: bursts limited to MAXB when the limit is built in
    step(1, 16'h0000, 0);
    repeat (20) step(0, 16'h0003, 1);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    $display("burst phase done at %0t", $time);

    // Backpressure then drop for owner 3; next ptr=4 picks 4 over 3
    step(1, 16'h0000, 0);
    step(0, 16'h0008, 0);
    repeat (3) step(0, 16'h0008, 0);
    step(0, 16'h0000, 1);
    repeat (3) step(0, 16'h0018, 1);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    $display("backpressure phase done at %0t", $time);

    // Mid-burst reset with owner 9; next winner is 1
    step(1, 16'h0000, 0);
    step(0, 16'h0200, 1);
    step(0, 16'h0200, 1);
    step(1, 16'h0202, 1);
    repeat (3) step(0, 16'h0202, 1);
    step(0, 16'h0000, 0);
    $display("mid-burst reset phase done at %0t", $time);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      q = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step($urandom_range(0, 49) == 0, q, $urandom_range(0, 3) != 0);
    end
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    @(negedge clk);
    #3;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("xfer_q_drained", 32'(xfer_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
